exu_seq: RTL
============

// Module: exu_seq
// PURPOSE
//  Parametrised next-generation execute unit: XLEN-wide ALU plus iterative multi-cycle
//  multiply/divide, wrapped in valid/ready handshakes on both sides. Sits between
//  IDU (operands/imm/op) and LSU/WBU; result is held until downstream accepts it.
// PARAMETERS
//  XLEN     32   datapath width (>=8, power of 2)
//  SHAMT_W  $clog2(XLEN)  localparam, shift amount width
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     reset: synchronous, active-low
//  in_valid     in   1     operand bundle valid
//  in_ready     out  1     unit can accept a bundle
//  src1         in   XLEN  rs1 data
//  src2         in   XLEN  rs2 data
//  imm          in   XLEN  immediate
//  use_imm      in   1     1: operand b = imm, 0: b = src2
//  op           in   4     operation code (see BEHAVIOUR)
//  out_valid    out  1     result valid
//  out_ready    in   1     downstream accepts result
//  result       out  XLEN  result
//  illegal      out  1     op unsupported in this build (qualified by out_valid)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, in_ready=1, out_valid=0, result=0,
//    illegal=0, counter=0. Reset mid-operation abandons the op, no output produced.
//  - a=src1, b=use_imm?imm:src2; both latched on accept (in_valid&&in_ready).
//  - op: 0 ADD a+b | 1 SUB a-b | 2 CMPU | 3 CMPS | 4 SRL | 5 SRA | 6 SLL
//        7 AND | 8 OR | 9 XOR | 10 MUL (low XLEN bits) | 11 DIVU | 12 REMU | 13-15 illegal.
//  - CMPU/CMPS three-way code: a==b -> 0; a>b -> 2; a<b -> 4 (unsigned / signed).
//  - Shifts use b[SHAMT_W-1:0] only; SRA replicates a[XLEN-1].
//  - ADD/SUB wrap modulo 2^XLEN; no flags exported.
//  - FSM IDLE -> (accept) -> BUSY or DONE; BUSY -> (counter==XLEN-1) -> DONE;
//    DONE -> (out_ready) -> IDLE.
//  - IDLE: in_ready=1, out_valid=0. Single-cycle ops (0-9, 13-15): result registered
//    on accept, out_valid=1 next cycle (latency 1).
//  - BUSY: in_ready=0; MUL shift-add, DIVU/REMU restoring, one bit per cycle, XLEN
//    cycles; out_valid rises XLEN+1 cycles after accept.
//  - DONE: out_valid=1, result/illegal held stable until out_ready=1; on that edge
//    -> IDLE. in_ready=0 in DONE, so no accept in the handshake cycle (max 1 op / 2 clk).
//  - in_valid while in_ready=0 ignored; upstream must hold bundle.
//  - Divide by zero: DIVU -> all ones, REMU -> a; still XLEN cycles.
//  - illegal=1 only for ops 13-15 (and 11/12 when divider compiled out); result=0.
// CONFIGURATION
//  EXU_SEQ_DIV_EN defined: ops 11/12 run the iterative divider as above.
//  Undefined: no divider logic; ops 11/12 take single-cycle path, result=0,
//  illegal=1, latency 1. MUL and all other ops unaffected.
// TESTING
//  1 reset: rst_n=0 two cycles mid-MUL -> out_valid=0, in_ready=1, result=0 after.
//  2 ADD src1=0xFFFFFFFF imm=1 use_imm=1 -> result=0 one cycle after accept;
//    CMPS a=0xFFFFFFFF b=1 -> 4; CMPU same -> 2; SRA a=0x80000000 b=4 -> 0xF8000000.
//  3 MUL 0x00012345*0x00000100 -> 0x01234500, out_valid exactly 33 cycles after accept,
//    in_ready=0 throughout.
//  4 backpressure: out_ready=0 for 5 cycles after result -> result stable, in_valid
//    ignored; out_ready=1 -> IDLE next cycle, new op accepted.
//  5 DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF, REMU 9/0 -> 9 (with EN).
//  6 without EXU_SEQ_DIV_EN: DIVU -> result=0, illegal=1, latency 1; op 15 -> illegal=1.

Source files
------------

// File: rtl/exu_seq_if.sv
// Handshake bundle between the issue stage, exu_seq and the result consumer.
// Latency: none, wiring only.
// Backpressure: carries in_valid/in_ready on the operand side and out_valid/out_ready on the result side.
// Ports (modport slave = execute unit, master = upstream/downstream driver):
//   in_valid/in_ready, src1, src2, imm, use_imm, op : operand bundle
//   out_valid/out_ready, result, illegal            : result bundle
interface exu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [3:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, src1, src2, imm, use_imm, op, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, src1, src2, imm, use_imm, op, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/exu_seq.sv
// Execute unit: XLEN-wide ALU plus iterative shift-add multiply and restoring divide.
// Latency: 1 cycle for ALU/illegal ops, XLEN+1 cycles for MUL (and DIVU/REMU when enabled).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (max one op per 2 clk).
// Ports: clk, rst_n (synchronous, active-low), bus (exu_seq_if.slave: operand and result handshakes).
// Build option: define EXU_SEQ_DIV_EN to include the divider; otherwise ops 11/12 report illegal.
module exu_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  exu_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMPU = 4'd2;
  localparam logic [3:0] OP_CMPS = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
`ifdef EXU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]    op_a, op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               multi;
  logic               last;
  logic [XLEN-1:0]    alu_res;
  logic               alu_ill;

  // Iteration registers. MUL: x = multiplicand (shifts left), y = multiplier
  // (shifts right), acc = partial product. DIV: x = dividend shifting out /
  // quotient shifting in, y = divisor, acc = partial remainder.
  logic [XLEN-1:0]    x_q, y_q, acc_q;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    result_q;
  logic               illegal_q;
  logic [XLEN-1:0]    mul_acc_nxt;

  assign op_a  = bus.src1;
  assign op_b  = bus.use_imm ? bus.imm : bus.src2;
  assign shamt = op_b[SHAMT_W-1:0];
  assign last  = (cnt == SHAMT_W'(XLEN - 1));

  assign mul_acc_nxt = y_q[0] ? (acc_q + x_q) : acc_q;

`ifdef EXU_SEQ_DIV_EN
  logic            div_q;   // iterative op is a divide, not a multiply
  logic            rem_q;   // divide returns the remainder
  logic [XLEN:0]   div_shift, div_trial;
  logic            div_ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  assign multi = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);

  // Partial remainder is always below the divisor, so the trial difference
  // fits in XLEN+1 bits and its top bit is a clean sign. A zero divisor never
  // borrows, which yields an all-ones quotient and remainder == dividend.
  assign div_shift = {acc_q, x_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, y_q};
  assign div_ge    = ~div_trial[XLEN];
  assign rem_nxt   = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_nxt   = {x_q[XLEN-2:0], div_ge};
`else
  assign multi = (bus.op == OP_MUL);
`endif

  // Single-cycle datapath. MUL/DIVU/REMU fall into the default arm, but when
  // they are iterative the accept logic ignores this output; without the
  // divider, 11/12 land here as illegal with a zero result.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_CMPU: alu_res = (op_a == op_b) ? XLEN'(0) : (op_a > op_b) ? XLEN'(2) : XLEN'(4);
      OP_CMPS: alu_res = (op_a == op_b) ? XLEN'(0) :
                         ($signed(op_a) > $signed(op_b)) ? XLEN'(2) : XLEN'(4);
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      OP_SLL:  alu_res = op_a << shamt;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = multi ? BUSY : DONE;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef EXU_SEQ_DIV_EN
      div_q     <= 1'b0;
      rem_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q   <= op_a;
            y_q   <= op_b;
            acc_q <= '0;
            cnt   <= '0;
`ifdef EXU_SEQ_DIV_EN
            div_q <= (bus.op == OP_DIVU) || (bus.op == OP_REMU);
            rem_q <= (bus.op == OP_REMU);
`endif
            if (multi) begin
              illegal_q <= 1'b0;
            end else begin
              result_q  <= alu_res;
              illegal_q <= alu_ill;
            end
          end
        end
        BUSY: begin
          // cnt wraps back to 0 after the last step
          cnt <= cnt + 1'b1;
`ifdef EXU_SEQ_DIV_EN
          if (div_q) begin
            acc_q <= rem_nxt;
            x_q   <= quo_nxt;
            if (last) result_q <= rem_q ? rem_nxt : quo_nxt;
          end else
`endif
          begin
            acc_q <= mul_acc_nxt;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
            if (last) result_q <= mul_acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;
endmodule
